// File: rtl/spi_regfile.sv
// SPI-addressed register file. The SPI pins are brought into the CLK domain
// through two-flop synchronisers. All frame decoding runs on CLK, driven by
// the edges detected after synchronisation.
// Frame: CS low, R/W bit (1 = read), ADDR_W address bits, then DATA_W-bit
// data words. The address auto-increments after each complete word.
module spi_regfile #(
    parameter int                NREG    = 2,
    parameter int                ADDR_W  = 8,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CS,
    input  logic                     SCLK,
    input  logic                     SDATA,
    output logic                     SDO,
    output logic                     SDO_OE,
    output logic [NREG*DATA_W-1:0]   REGS,
    output logic                     WSTB,
    output logic [ADDR_W-1:0]        WADDR
);

    // The command and data phases share one bit counter. It is sized for
    // the longer of the two phases.
    localparam int CMD_BITS = ADDR_W + 1;
    localparam int MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
    localparam int CNT_W    = $clog2(MAX_BITS);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    // Stages 0 and 1 form the synchroniser. Stage 2 is the delayed copy
    // that the edge detectors compare against.
    logic [2:0] cs_sync_q;
    logic [2:0] sclk_sync_q;
    logic [1:0] sdata_sync_q;

    logic cs_rise;
    logic cs_fall;
    logic sclk_rise;
    logic sclk_fall;
    logic sdata_bit;

    // Shift the raw pins into the synchroniser chains.
    // Reset makes the chains look like an idle bus.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_sync_q    <= 3'b111;
            sclk_sync_q  <= 3'b000;
            sdata_sync_q <= 2'b00;
        end else begin
            cs_sync_q    <= {cs_sync_q[1:0], CS};
            sclk_sync_q  <= {sclk_sync_q[1:0], SCLK};
            sdata_sync_q <= {sdata_sync_q[0], SDATA};
        end
    end

    assign cs_rise   =  cs_sync_q[1]   & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1]   &  cs_sync_q[2];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign sdata_bit =  sdata_sync_q[1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                  state_q,   state_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [CMD_BITS-1:0]     cmd_sr_q,  cmd_sr_d;
    logic                    rw_q,      rw_d;
    logic [ADDR_W-1:0]       addr_q,    addr_d;
    logic [DATA_W-1:0]       dsr_q,     dsr_d;
    logic [DATA_W-1:0]       rd_sr_q,   rd_sr_d;
    logic                    wr_pend_q, wr_pend_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]       wr_ptr_q,  wr_ptr_d;
    logic                    wstb_q,    wstb_d;
    logic [ADDR_W-1:0]       waddr_q,   waddr_d;

    logic [NREG*DATA_W-1:0]  regs_flat;

    // Returns the register at address a. Addresses with no register
    // behind them read as zero.
    function automatic logic [DATA_W-1:0] reg_lookup(
        input logic [NREG*DATA_W-1:0] flat,
        input logic [ADDR_W-1:0]      a
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < NREG; k++) begin
            if (a == ADDR_W'(k)) begin
                r = flat[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    // Returns 1 if address a selects a register that exists.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        logic v;
        v = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            if (a == ADDR_W'(k)) begin
                v = 1'b1;
            end
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Hold the frame state. Reset forces IDLE, even in the middle of a frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // A CS rise always returns the FSM to IDLE. In DATA, the datapath still
    // finishes any word completed on that same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end else if (sclk_rise && (cnt_q == CMD_LAST)) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Drive the pad only during the data phase of a read.
    // SDO is held low whenever the pad is not driven.
    always_comb begin
        SDO_OE = (state_q == S_DATA) && rw_q;
        SDO    = SDO_OE && rd_sr_q[DATA_W-1];
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    // Shift the command and data bits, and handle word completion and
    // address auto-increment.
    // A completed write word is staged in wr_* and committed one CLK later.
    always_comb begin
        cnt_d     = cnt_q;
        cmd_sr_d  = cmd_sr_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        dsr_d     = dsr_q;
        rd_sr_d   = rd_sr_q;
        wr_pend_d = 1'b0;
        wr_data_d = wr_data_q;
        wr_ptr_d  = wr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    cnt_d = '0;
                end
            end
            S_CMD: begin
                if (!cs_rise && sclk_rise) begin
                    cmd_sr_d = {cmd_sr_q[CMD_BITS-2:0], sdata_bit};
                    if (cnt_q == CMD_LAST) begin
                        cnt_d   = '0;
                        rw_d    = cmd_sr_d[CMD_BITS-1];
                        addr_d  = cmd_sr_d[ADDR_W-1:0];
                        // Capture the first read word as the phase starts.
                        rd_sr_d = reg_lookup(regs_flat, cmd_sr_d[ADDR_W-1:0]);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (sclk_rise) begin
                    dsr_d = DATA_W'({dsr_q, sdata_bit});
                    if (cnt_q == DATA_LAST) begin
                        wr_pend_d = !rw_q;
                        wr_data_d = dsr_d;
                        wr_ptr_d  = addr_q;
                        addr_d    = addr_q + 1'b1;
                        rd_sr_d   = reg_lookup(regs_flat, addr_q + 1'b1);
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sclk_fall && (cnt_q != '0)) begin
                    // A zero count means a fresh word: its MSB is already on
                    // SDO and must stay there until the next rise.
                    rd_sr_d = DATA_W'({rd_sr_q, 1'b0});
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Strobe the commit of a staged write, but only for an address that
    // selects a real register.
    always_comb begin
        wstb_d  = 1'b0;
        waddr_d = waddr_q;
        if (wr_pend_q && addr_valid(wr_ptr_q)) begin
            wstb_d  = 1'b1;
            waddr_d = wr_ptr_q;
        end
    end

    // Register the datapath state and the write-strobe outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            cmd_sr_q  <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            dsr_q     <= '0;
            rd_sr_q   <= '0;
            wr_pend_q <= 1'b0;
            wr_data_q <= '0;
            wr_ptr_q  <= '0;
            wstb_q    <= 1'b0;
            waddr_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cmd_sr_q  <= cmd_sr_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            dsr_q     <= dsr_d;
            rd_sr_q   <= rd_sr_d;
            wr_pend_q <= wr_pend_d;
            wr_data_q <= wr_data_d;
            wr_ptr_q  <= wr_ptr_d;
            wstb_q    <= wstb_d;
            waddr_q   <= waddr_d;
        end
    end

    assign WSTB  = wstb_q;
    assign WADDR = waddr_q;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // Each register gets its own flop bank, because every register is
    // visible on the REGS bus at all times.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        logic [DATA_W-1:0] reg_q;

        // Commit the staged write word when it targets this register.
        always_ff @(posedge CLK) begin
            if (RST) begin
                reg_q <= RST_VAL;
            end else if (wr_pend_q && (wr_ptr_q == ADDR_W'(gi))) begin
                reg_q <= wr_data_q;
            end
        end

        assign regs_flat[gi*DATA_W +: DATA_W] = reg_q;
    end

    assign REGS = regs_flat;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed testbench for spi_regfile with the default parameters
// (NREG=2, ADDR_W=8, DATA_W=8, RST_VAL=0).
// Expected write strobes and read words go into scoreboard queues when a
// frame is driven. They are popped and compared when the DUT produces them.
module tb_spi_regfile;

    localparam int HALF = 6;    // SCLK half period, in CLK cycles

    logic        clk;
    logic        rst;
    logic        cs;
    logic        sclk;
    logic        sdata;
    logic        sdo;
    logic        sdo_oe;
    logic [15:0] regs;
    logic        wstb;
    logic [7:0]  waddr;

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] wq[$];     // expected writes: {addr, data}
    logic [7:0]  rq[$];     // expected read words
    logic [15:0] mon_e;
    logic [7:0]  mon_obs;

    spi_regfile #(
        .NREG    (2),
        .ADDR_W  (8),
        .DATA_W  (8),
        .RST_VAL (8'h00)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .CS     (cs),
        .SCLK   (sclk),
        .SDATA  (sdata),
        .SDO    (sdo),
        .SDO_OE (sdo_oe),
        .REGS   (regs),
        .WSTB   (wstb),
        .WADDR  (waddr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send one mode-0 bit. MISO and OE are sampled just before the SCLK rise,
    // which is where the master would sample them.
    task automatic spi_bit(input logic mosi, output logic miso, output logic oe);
        sdata = mosi;
        clk_wait(HALF);
        miso = sdo;
        oe   = sdo_oe;
        sclk = 1'b1;
        clk_wait(HALF);
        sclk = 1'b0;
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        clk_wait(HALF);
    endtask

    task automatic cs_end();
        clk_wait(HALF);
        cs = 1'b1;
        clk_wait(2 * HALF);
    endtask

    task automatic send_cmd(input logic rw, input logic [7:0] a, output logic oe_any);
        logic m;
        logic o;
        spi_bit(rw, m, o);
        oe_any = o;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(a[i], m, o);
            oe_any = oe_any | o;
        end
    endtask

    task automatic send_word(input logic [7:0] d, input int nbits,
                             output logic [7:0] rd, output logic oe_all);
        logic m;
        logic o;
        rd     = '0;
        oe_all = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(d[7-i], m, o);
            rd     = {rd[6:0], m};
            oe_all = oe_all & o;
        end
    endtask

    // Match every WSTB pulse against the write scoreboard.
    always @(negedge clk) begin
        if (wstb === 1'b1) begin
            check("wstb_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                mon_e   = wq.pop_front();
                mon_obs = (mon_e[15:8] == 8'd0) ? regs[7:0] : regs[15:8];
                $display("write strobe: waddr=%0h regs=%04h", waddr, regs);
                check("wstb_waddr", 32'(waddr), 32'(mon_e[15:8]));
                check("wstb_regdata", 32'(mon_obs), 32'(mon_e[7:0]));
            end
        end
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] e;
        logic       oe_any;
        logic       oe_all;

        rst   = 1'b1;
        cs    = 1'b1;
        sclk  = 1'b0;
        sdata = 1'b0;
        clk_wait(4);
        check("rst_regs",   32'(regs),   32'h0);
        check("rst_sdo",    32'(sdo),    32'h0);
        check("rst_sdo_oe", 32'(sdo_oe), 32'h0);
        check("rst_wstb",   32'(wstb),   32'h0);
        check("rst_waddr",  32'(waddr),  32'h0);
        rst = 1'b0;
        clk_wait(4);
        check("idle_regs", 32'(regs), 32'h0);

        // Single write: addr 0x01 <= 0xA5.
        wq.push_back({8'h01, 8'hA5});
        cs_begin();
        send_cmd(1'b0, 8'h01, oe_any);
        send_word(8'hA5, 8, rd, oe_all);
        cs_end();
        $display("single write done: regs=%04h", regs);
        check("t1_regs", 32'(regs), 32'h0000A500);
        check("t1_oe",   32'(oe_any | oe_all), 32'h0);

        // Burst write from addr 0x00: 0x11, 0x22.
        wq.push_back({8'h00, 8'h11});
        wq.push_back({8'h01, 8'h22});
        cs_begin();
        send_cmd(1'b0, 8'h00, oe_any);
        send_word(8'h11, 8, rd, oe_all);
        send_word(8'h22, 8, rd, oe_all);
        cs_end();
        $display("burst write done: regs=%04h", regs);
        check("burst_regs", 32'(regs), 32'h00002211);

        // Burst read from 0x01: 0x22, then 0x00 from unmapped 0x02.
        rq.push_back(8'h22);
        rq.push_back(8'h00);
        cs_begin();
        send_cmd(1'b1, 8'h01, oe_any);
        check("rd_cmd_oe", 32'(oe_any), 32'h0);
        for (int w = 0; w < 2; w++) begin
            send_word(8'h00, 8, rd, oe_all);
            e = rq.pop_front();
            $display("read word %0d: sdo=%02h", w, rd);
            check("rd_data", 32'(rd), 32'(e));
            check("rd_oe",   32'(oe_all), 32'h1);
        end
        cs_end();
        check("rd_oe_after",  32'(sdo_oe), 32'h0);
        check("rd_sdo_after", 32'(sdo),    32'h0);
        check("rd_regs",      32'(regs),   32'h00002211);

        // Write to unmapped addr 0x05: no change, no strobe.
        cs_begin();
        send_cmd(1'b0, 8'h05, oe_any);
        send_word(8'hFF, 8, rd, oe_all);
        cs_end();
        $display("unmapped write done: regs=%04h", regs);
        check("oor_regs", 32'(regs), 32'h00002211);

        // Partial word (5 bits), then a full write of 0x3C to addr 0x00.
        cs_begin();
        send_cmd(1'b0, 8'h00, oe_any);
        send_word(8'hC3, 5, rd, oe_all);
        cs_end();
        $display("partial write done: regs=%04h", regs);
        check("partial_regs", 32'(regs),   32'h00002211);
        check("partial_oe",   32'(sdo_oe), 32'h0);
        wq.push_back({8'h00, 8'h3C});
        cs_begin();
        send_cmd(1'b0, 8'h00, oe_any);
        send_word(8'h3C, 8, rd, oe_all);
        cs_end();
        $display("follow-up write done: regs=%04h", regs);
        check("after_partial_regs", 32'(regs), 32'h0000223C);

        // One-CLK reset pulse in the middle of a data word.
        cs_begin();
        send_cmd(1'b0, 8'h01, oe_any);
        send_word(8'h77, 4, rd, oe_all);
        rst = 1'b1;
        clk_wait(1);
        rst = 1'b0;
        $display("mid-frame reset: regs=%04h", regs);
        check("mrst_regs", 32'(regs),   32'h0);
        check("mrst_wstb", 32'(wstb),   32'h0);
        check("mrst_oe",   32'(sdo_oe), 32'h0);
        send_word(8'h07, 4, rd, oe_all);
        cs_end();
        check("mrst_tail_regs", 32'(regs), 32'h0);
        wq.push_back({8'h01, 8'h5A});
        cs_begin();
        send_cmd(1'b0, 8'h01, oe_any);
        send_word(8'h5A, 8, rd, oe_all);
        cs_end();
        $display("post-reset write done: regs=%04h", regs);
        check("mrst_write_regs", 32'(regs), 32'h00005A00);

        // Read back both registers from 0x00.
        rq.push_back(8'h00);
        rq.push_back(8'h5A);
        cs_begin();
        send_cmd(1'b1, 8'h00, oe_any);
        for (int w = 0; w < 2; w++) begin
            send_word(8'h00, 8, rd, oe_all);
            e = rq.pop_front();
            $display("readback word %0d: sdo=%02h", w, rd);
            check("rb_data", 32'(rd), 32'(e));
        end
        cs_end();

        clk_wait(4);
        check("wq_drained", 32'(wq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/spi_regfile.md
Name: spi_regfile

Overview:
- Next-generation SPI register block, single system clock domain.
- SPI pins are synchronised and oversampled on CLK, so CS is no longer used as a clock.
- Supports write and read-back, burst transfers with address auto-increment, and a parametrised register count and width.
- Sits between the board SPI pins and the design's control registers; it exposes all registers as one flat bus plus a per-word write strobe.

Parameters:
- NREG, 2, number of registers (1..2**ADDR_W).
- ADDR_W, 8, address field width in bits.
- DATA_W, 8, register and data-word width in bits.
- RST_VAL, 0, reset value of every register (DATA_W bits).

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- CS  input  1  SPI chip select, active low, asynchronous to CLK.
- SCLK  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to CLK.
- SDATA  input  1  MOSI, MSB first.
- SDO  output  1  MISO, MSB first.
- SDO_OE  output  1  high while a read data phase is active (pad tristate enable).
- REGS  output  NREG*DATA_W  register file; register k occupies bits [k*DATA_W +: DATA_W].
- WSTB  output  1  one-CLK pulse when a register is written.
- WADDR  output  ADDR_W  address of the write signalled by WSTB.

Behaviour:
- Reset, while RST=1 on a CLK edge:
  - all registers = RST_VAL; SDO=0, SDO_OE=0, WSTB=0, WADDR=0;
  - FSM to IDLE, bit counters cleared, synchroniser flops set to CS=1, SCLK=0.
- Reset dominates all other events, including mid-frame.
- Synchronisation:
  - CS, SCLK and SDATA each pass through 2 flops; edges are detected from the 2nd and 3rd stages.
  - SCLK high and low times must each be at least 3 CLK periods.
  - SDATA must be stable for 3 CLK before the SCLK rise.
- Frame format:
  - CS falls, then 1 R/W bit (1=read, 0=write), then ADDR_W address bits, then one or more DATA_W data words.
  - SDATA is sampled on the synchronised SCLK rising edge.
- FSM states:
  - IDLE: on synchronised CS fall, go to CMD and clear the bit counter.
  - CMD: shift SDATA on each SCLK rise. After 1+ADDR_W bits, latch rw and addr and go to DATA. On a read, also load the read shift register from regs[addr], or 0 if addr>=NREG.
  - DATA: shift on each SCLK rise. After DATA_W bits:
    - write: if addr<NREG, regs[addr] <= word on the next CLK, with WSTB=1 and WADDR=addr for exactly that CLK. If addr>=NREG, no register changes and no WSTB.
    - then, for both read and write: addr <= addr+1 (wraps modulo 2**ADDR_W), reload the read shift register from the new addr, clear the counter, and stay in DATA.
  - Any state: synchronised CS rise returns to IDLE.
- Partial words:
  - A partial command or partial data word at CS rise is discarded; no write and no WSTB.
- Read output:
  - SDO_OE=1 from entry to DATA with rw=1 until CS rise.
  - SDO presents the shift register MSB from DATA entry.
  - SDO advances one bit on each synchronised SCLK fall within a word. After a word boundary, the new word's MSB is presented before the next SCLK rise.
  - SDO=0 whenever SDO_OE=0.
- Read/write interaction:
  - Reads never modify registers.
  - A register value is captured at word start, so a write in the same burst to a later address is not visible until that word is read.
- Latency: CS/SCLK edge to internal action is 3 CLK; completion of the last data bit to REGS update is 4 CLK.
- Simultaneous events: if CS rise and the final data bit's SCLK rise land on the same synchronised CLK, the word completes and is written first, then the FSM returns to IDLE.
- SCLK edges while CS is high are ignored.

Test Plan:
- Reset, then a single write frame: R/W=0, addr=0x01, data=0xA5 -> REGS[15:8]=0xA5, REGS[7:0]=RST_VAL, one WSTB pulse with WADDR=0x01.
- Burst write from addr=0x00 with words 0x11, 0x22 (NREG=2) -> reg0=0x11 and reg1=0x22, two WSTB pulses with WADDR 0x00 then 0x01.
- Read frame at addr=0x01 after the previous test, clocking 16 data bits -> SDO shifts 0x22, then 0x00 for out-of-range address 0x02; SDO_OE high only during the data phase.
- Write to addr=0x05 (>=NREG) with data 0xFF -> all REGS unchanged, no WSTB.
- Write addr=0x00, but CS rises after 5 data bits -> reg0 unchanged, no WSTB, FSM in IDLE; an immediately following full write of 0x3C lands correctly.
- Assert RST for 1 CLK mid-way through a data word, then send a complete write of 0x5A to addr 0x01 -> all REGS=RST_VAL after reset, then reg1=0x5A.
